trigger_capture: RTL
====================

Name: trigger_capture

Overview:
Edge-triggered acquisition buffer between the ADC channel output and the VGA wave renderer.
- Watches the sample stream for a level crossing and captures DEPTH consecutive samples into a ping-pong RAM.
- Presents the last completed capture to the display, indexed by screen X, so the trace is stable and tear-free.
- Replaces free-running sampling for the scope's signal inputs.

Parameters:
DATA_W, 12, sample width (ADC channel width)
DEPTH, 640, samples per capture (one per screen column)
ADDR_W, 10, capture address width; must satisfy 2**ADDR_W >= DEPTH
X_W, 11, screen X coordinate width
TIMEOUT, 65535, samples without a trigger before an auto trigger (used only with the optional feature)

Ports:
clock  in  1  system clock; all logic is in this single domain
reset_n  in  1  asynchronous active-low reset
sample_en  in  1  one-cycle strobe; data_in is valid on this cycle
data_in  in  DATA_W  ADC sample
trig_level  in  DATA_W  trigger threshold, unsigned
trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
run  in  1  1 = continuous re-arm; 0 = single shot
arm  in  1  one-cycle pulse that arms a capture in single-shot mode
screenX  in  X_W  display column being drawn
screenData  out  DATA_W  stored sample for screenX, registered
capturing  out  1  high while in CAPTURE
resample  out  1  one-cycle pulse when a new capture becomes visible
triggered_auto  out  1  1 = last displayed capture was forced by timeout

Behaviour:
Reset values:
- All outputs are 0.
- State is IDLE, display bank = 0, write bank = 1, prev sample = 0, the prev-valid flag is cleared, counters are 0.
- RAM contents are undefined; screenData still reads 0 until the first swap (guarded by a seen_capture flag).

Trigger detection (evaluated only on sample_en cycles):
- Rising edge: prev < trig_level && data_in >= trig_level.
- Falling edge: prev >= trig_level && data_in < trig_level.
- prev updates on every sample_en, in every state.
- No trigger is possible until prev-valid is set, i.e. on the first sample after reset.

State machine:
- IDLE: if run, go to ARMED; else if arm, go to ARMED; else stay.
- ARMED: on a trigger, write the triggering sample at address 0, set wr_addr = 1, go to CAPTURE.
- CAPTURE: each sample_en writes data_in to the write bank at wr_addr and increments it. The write of address DEPTH-1 moves the state to SWAP on the next cycle. Samples arriving without sample_en are ignored.
- SWAP (exactly one cycle): exchange the banks, pulse resample, set seen_capture. Next state is ARMED if run, else IDLE.

Timing and latency:
- Trigger sample to capturing high: 1 cycle.
- The last write to resample: 1 cycle.
- Total capture time is exactly DEPTH sample_en strobes.

Read side:
- screenData is the display bank word at screenX, registered; latency is 1 cycle from screenX.
- If screenX >= DEPTH, screenData = 0.
- During SWAP, a read issued that cycle uses the old bank. The new bank is used from the following cycle.

Boundary and priority rules:
- A trigger condition while in CAPTURE or SWAP is ignored.
- arm while not in IDLE is ignored.
- Clearing run mid-capture: the current capture completes, then the block goes to IDLE.
- Changing trig_level or trig_falling mid-capture takes effect at the next ARMED.
- Asserting reset_n low mid-capture aborts it: the display bank and seen_capture clear and screenData returns 0.
- Comparisons are unsigned and at full width; there is no hysteresis.

Optional Feature:
TRIGGER_CAPTURE_AUTO_EN
- Defined: in ARMED, a counter counts sample_en strobes. When it reaches TIMEOUT with no trigger, a forced trigger occurs on that sample, exactly like a real trigger, and triggered_auto is latched to 1 at the resulting SWAP. A real trigger latches triggered_auto to 0 at its SWAP. The counter clears on entry to ARMED.
- Undefined: the block waits indefinitely in ARMED, triggered_auto is tied to 0 and no counter is built.

Decomposition:
- Shared package: DATA_W and X_W defaults, the screen width constant (640), and the state enum IDLE, ARMED, CAPTURE, SWAP.
- One sub-module is natural: capture_ram, a simple dual-port RAM with DEPTH*2 words. Address = {bank, addr}. It has one write port and one registered read port, so it can be inferred as block RAM.
- Trigger compare, FSM and bank logic stay in the top.

Test Plan:
1. Rising trigger: level=2048, rising; ramp 0..4095 step 16 with sample_en every 4 cycles. The first stored word is 2048, with no out-of-order value preceding it. screenX=0 gives 2048 and screenX=1 gives 2064, one cycle after the address is applied. resample pulses once after 640 strobes.
2. Falling trigger: a square wave 1000/3000 with level 2000 and trig_falling=1. Word 0 = 1000. No capture starts on rising edges.
3. Single shot: run=0 with no arm and a toggling signal. No resample pulse occurs and screenData stays 0. After an arm pulse there is exactly one capture, then the block returns to IDLE.
4. Tear-free display: sweep screenX continuously during a second capture. Reads return the first capture until the SWAP cycle, and the new data appears on the following cycle.
5. Reset mid-capture: assert reset_n low at wr_addr=300. All outputs go to 0 immediately (asynchronously). After release the block returns to IDLE/ARMED and completes a full 640-sample capture.
6. Auto trigger (macro defined): TIMEOUT=100 with a constant input of 500 and level 2048. Capture starts on the 100th strobe, and triggered_auto=1 after the swap.

Source files
------------

// File: rtl/trigger_capture_pkg.sv
// rtl/trigger_capture_pkg.sv - shared constants and state encoding for the trigger capture buffer
package trigger_capture_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int X_W_DEF    = 11;
    localparam int SCREEN_W   = 640;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        SWAP
    } state_t;

endpackage

// File: rtl/trigger_capture_if.sv
// rtl/trigger_capture_if.sv - sample, trigger control and display read signals of the capture buffer
interface trigger_capture_if #(
    parameter int DATA_W = 12,
    parameter int X_W    = 11
);
    logic              sample_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] trig_level;
    logic              trig_falling;
    logic              run;
    logic              arm;
    logic [X_W-1:0]    screenX;
    logic [DATA_W-1:0] screenData;
    logic              capturing;
    logic              resample;
    logic              triggered_auto;

    modport master (
        output sample_en, data_in, trig_level, trig_falling, run, arm, screenX,
        input  screenData, capturing, resample, triggered_auto
    );

    modport slave (
        input  sample_en, data_in, trig_level, trig_falling, run, arm, screenX,
        output screenData, capturing, resample, triggered_auto
    );
endinterface

// File: rtl/trigger_capture_capture_ram.sv
// rtl/trigger_capture_capture_ram.sv - two-bank simple dual-port capture RAM, registered read
module capture_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W:0]   raddr,
    output logic [DATA_W-1:0] rdata
);
    // Address is {bank, addr}, so each bank occupies a full power-of-two half.
    logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/trigger_capture.sv
// rtl/trigger_capture.sv - edge-triggered ping-pong capture buffer for the wave display
// Optional timeout auto trigger: define TRIGGER_CAPTURE_AUTO_EN.
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = SCREEN_W,
    parameter int ADDR_W  = 10,
    parameter int X_W     = X_W_DEF,
    parameter int TIMEOUT = 65535
) (
    input  logic            clock,
    input  logic            reset_n,
    trigger_capture_if.slave bus
);
    if (DEPTH > 2**ADDR_W || TIMEOUT < 1) begin : g_cfg_check
        $error("trigger_capture: invalid DEPTH/ADDR_W/TIMEOUT");
    end

    state_t            state;
    logic              disp_bank;
    logic              seen_capture;
    logic              prev_valid;
    logic              rd_valid;
    logic              capturing_q;
    logic              resample_q;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] wr_addr;
    logic              rise;
    logic              fall;
    logic              hit;
    logic              force_trig;
    logic              start;
    logic              ram_we;
    logic              in_range;
    logic [ADDR_W:0]   ram_waddr;
    logic [ADDR_W:0]   ram_raddr;

    assign rise  = prev_valid && (prev < bus.trig_level) && (bus.data_in >= bus.trig_level);
    assign fall  = prev_valid && (prev >= bus.trig_level) && (bus.data_in < bus.trig_level);
    assign hit   = bus.sample_en && (bus.trig_falling ? fall : rise);
    assign start = (state == ARMED) && (hit || force_trig);

    // The write bank is always the one not on display.
    assign ram_we    = start || ((state == CAPTURE) && bus.sample_en);
    assign ram_waddr = {~disp_bank, (state == CAPTURE) ? wr_addr : {ADDR_W{1'b0}}};
    assign ram_raddr = {disp_bank, bus.screenX[ADDR_W-1:0]};
    assign in_range  = bus.screenX < X_W'(DEPTH);

    capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (bus.data_in),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            disp_bank    <= 1'b0;
            seen_capture <= 1'b0;
            prev         <= '0;
            prev_valid   <= 1'b0;
            wr_addr      <= '0;
            rd_valid     <= 1'b0;
            capturing_q  <= 1'b0;
            resample_q   <= 1'b0;
        end else begin
            resample_q <= 1'b0;
            // Read gating uses the flags as they stood when the address was sampled.
            rd_valid   <= seen_capture && in_range;
            if (bus.sample_en) begin
                prev       <= bus.data_in;
                prev_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.run || bus.arm) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (start) begin
                        wr_addr     <= ADDR_W'(1);
                        capturing_q <= 1'b1;
                        state       <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (bus.sample_en) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_addr == ADDR_W'(DEPTH - 1)) begin
                            capturing_q <= 1'b0;
                            resample_q  <= 1'b1;
                            state       <= SWAP;
                        end
                    end
                end
                SWAP: begin
                    disp_bank    <= ~disp_bank;
                    seen_capture <= 1'b1;
                    state        <= bus.run ? ARMED : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.screenData = rd_valid ? ram_rdata : '0;
    assign bus.capturing  = capturing_q;
    assign bus.resample   = resample_q;

`ifdef TRIGGER_CAPTURE_AUTO_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] auto_cnt;
    logic             auto_pend;
    logic             auto_flag;

    // Counter is held at zero outside ARMED, so it restarts on every entry.
    assign force_trig = bus.sample_en && (auto_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            auto_cnt  <= '0;
            auto_pend <= 1'b0;
            auto_flag <= 1'b0;
        end else begin
            if (state != ARMED) begin
                auto_cnt <= '0;
            end else if (bus.sample_en) begin
                auto_cnt <= auto_cnt + 1'b1;
            end
            if (start) begin
                auto_pend <= ~hit;
            end
            if (state == SWAP) begin
                auto_flag <= auto_pend;
            end
        end
    end

    assign bus.triggered_auto = auto_flag;
`else
    assign force_trig         = 1'b0;
    assign bus.triggered_auto = 1'b0;
`endif

endmodule
